// File: rtl/pattern_sequencer.sv
// pattern_sequencer: beat-driven pattern/hue sequencer whose visible changes land only on frame_start.
module pattern_sequencer #(
  parameter int NUM_PATTERNS      = 6,
  parameter int PAT_W             = 3,
  parameter int BEATS_PER_PATTERN = 4,
  parameter int HUE_STEP          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             frame_start,
  input  logic             hold,
  input  logic             step,
  output logic [PAT_W-1:0] pattern_sel,
  output logic [7:0]       hue,
  output logic [7:0]       beat_phase,
  output logic             pattern_change
);
  typedef enum logic {RUN, HOLD} state_t;
  localparam logic [7:0]       LAST_BEAT = 8'(BEATS_PER_PATTERN - 1);
  localparam logic [7:0]       HSTEP     = 8'(HUE_STEP);
  localparam logic [PAT_W-1:0] LAST_PAT  = PAT_W'(NUM_PATTERNS - 1);
  state_t     state;
  logic [7:0] hue_acc;
  logic       adv_pending, chg_d;
  logic       beat_tick, wrap, req;
  always_comb begin
    beat_tick = tick && state == RUN;
    wrap      = beat_tick && beat_phase == LAST_BEAT;
    req       = step || wrap;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= RUN;
      hue_acc        <= '0;
      adv_pending    <= 1'b0;
      chg_d          <= 1'b0;
      pattern_sel    <= '0;
      hue            <= '0;
      beat_phase     <= '0;
      pattern_change <= 1'b0;
    end else begin
      state <= hold ? HOLD : RUN;
      if (beat_tick) begin
        hue_acc    <= hue_acc + HSTEP;
        beat_phase <= wrap ? 8'd0 : beat_phase + 8'd1;
      end
      // a request arriving with frame_start survives for the next frame
      adv_pending    <= req || (adv_pending && !frame_start);
      chg_d          <= frame_start && adv_pending;
      pattern_change <= chg_d;
      if (frame_start) begin
        hue <= hue_acc;
        if (adv_pending) pattern_sel <= (pattern_sel == LAST_PAT) ? '0 : pattern_sel + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: randomized + directed scoreboard bench against a frame-level reference model.
module tb_pattern_sequencer;
  localparam int NP = 6, PW = 3, BPP = 4, HS = 16;
  logic          clk = 0, rst_n = 0, tick = 0, frame_start = 0, hold = 0, step = 0;
  logic [PW-1:0] pattern_sel;
  logic [7:0]    hue, beat_phase;
  logic          pattern_change;
  pattern_sequencer #(.NUM_PATTERNS(NP), .PAT_W(PW), .BEATS_PER_PATTERN(BPP), .HUE_STEP(HS)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .frame_start(frame_start), .hold(hold), .step(step),
    .pattern_sel(pattern_sel), .hue(hue), .beat_phase(beat_phase), .pattern_change(pattern_change)
  );
  always #5 clk = ~clk;
  typedef struct {int pat; int hue; int bp; int chg;} exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;
  // reference model: counts of effective beats and requests, visible state latched per frame
  int  run_ticks, m_pat, m_hue, chg_next, chg_now;
  bit  pend, was_hold;
  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask
  task automatic cyc(input bit t, input bit f, input bit s);
    exp_t e;
    bit   eff;
    tick = t; frame_start = f; step = s;
    if (!rst_n) begin
      run_ticks = 0; m_pat = 0; m_hue = 0; chg_next = 0; chg_now = 0; pend = 0; was_hold = 0;
    end else begin
      eff      = t && !was_hold;
      chg_now  = chg_next;
      chg_next = (f && pend) ? 1 : 0;
      if (f) begin
        m_hue = (run_ticks * HS) % 256;
        if (pend) m_pat = (m_pat + 1) % NP;
      end
      pend = (pend && !f) || s || (eff && (run_ticks % BPP) == BPP - 1);
      if (eff) run_ticks++;
      was_hold = hold;
    end
    e = '{pat: m_pat, hue: m_hue, bp: run_ticks % BPP, chg: chg_now};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0);
  endtask
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pattern_sel", int'(pattern_sel), e.pat);
      chk("hue", int'(hue), e.hue);
      chk("beat_phase", int'(beat_phase), e.bp);
      chk("pattern_change", int'(pattern_change), e.chg);
    end
  end
  initial begin
    rst_n = 0;
    idle(3);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin cyc(1, 0, 0); idle(49); end
    cyc(0, 1, 0);
    idle(3);
    chk("t1_pat", int'(pattern_sel), 1);
    chk("t1_hue", int'(hue), 64);
    for (int g = 0; g < 6; g++) begin
      repeat (4) begin cyc(1, 0, 0); idle(2); end
      cyc(0, 1, 0);
      idle(3);
    end
    chk("t2_pat", int'(pattern_sel), 1);
    cyc(0, 0, 1); idle(1); cyc(0, 0, 1);
    repeat (4) cyc(1, 0, 0);
    cyc(0, 1, 0); idle(3);
    chk("t3_pat", int'(pattern_sel), 2);
    cyc(0, 1, 0); idle(3);
    chk("t3_pat_again", int'(pattern_sel), 2);
    hold = 1;
    idle(1);
    repeat (8) begin cyc(1, 0, 0); idle(1); end
    cyc(0, 1, 0); idle(2);
    chk("t4_hold_pat", int'(pattern_sel), 2);
    cyc(0, 0, 1); cyc(0, 1, 0); idle(2);
    chk("t4_step_pat", int'(pattern_sel), 3);
    hold = 0;
    idle(1);
    while (run_ticks % BPP != BPP - 1) cyc(1, 0, 0);
    cyc(1, 1, 0); idle(3);
    chk("t5_no_adv", int'(pattern_sel), 3);
    cyc(0, 1, 0); idle(3);
    chk("t5_adv", int'(pattern_sel), 4);
    rst_n = 0; idle(1); rst_n = 1;
    repeat (3) cyc(1, 0, 0);
    cyc(0, 0, 1);
    rst_n = 0; idle(1); rst_n = 1;
    cyc(0, 1, 0); idle(3);
    chk("t6_pat", int'(pattern_sel), 0);
    chk("t6_hue", int'(hue), 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) hold = ~hold;
      rst_n = ($urandom_range(0, 399) != 0);
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end
    rst_n = 1; hold = 0;
    idle(2);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
- Consumes the one-cycle tempo tick (the half-second pulse) and drives the pattern-generation stage of the video pipeline.
- Counts beats and advances a pattern index every BEATS_PER_PATTERN beats.
- Steps a hue value on every beat.
- Applies all visible changes only on a frame-start pulse, so no pattern or hue change occurs mid-frame (tear-free).
- A hold input freezes automatic sequencing. A manual step input forces an advance.

Parameters:
- NUM_PATTERNS, 6, number of patterns; pattern index wraps NUM_PATTERNS-1 -> 0 (legal range 2..2**PAT_W).
- PAT_W, 3, width of pattern index.
- BEATS_PER_PATTERN, 4, ticks per automatic pattern advance (legal range 1..256).
- HUE_STEP, 16, hue increment per tick, modulo 256.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- tick  in  1  one-cycle beat pulse from the tempo stage.
- frame_start  in  1  one-cycle pulse at start of vertical blanking.
- hold  in  1  level; 1 = HOLD state, automatic sequencing frozen.
- step  in  1  one-cycle manual-advance pulse (already debounced and synchronised).
- pattern_sel  out  PAT_W  current pattern index (registered).
- hue  out  8  current hue (registered).
- beat_phase  out  8  current beat count within pattern, 0..BEATS_PER_PATTERN-1.
- pattern_change  out  1  one-cycle pulse in the cycle after pattern_sel updates.

Behaviour:
- Reset (rst_n=0 at a clk edge) values:
  - pattern_sel=0, hue=0, beat_phase=0, pattern_change=0.
  - Internal: hue_acc=0, adv_pending=0, state=RUN.
  - Reset mid-operation discards any pending advance and pending hue.
- States: RUN, HOLD.
  - Next state is HOLD when hold=1 and RUN when hold=0, evaluated every cycle.
  - The effect of the state applies from the cycle after the hold change.
- RUN, on tick:
  - hue_acc += HUE_STEP (mod 256).
  - If beat_phase == BEATS_PER_PATTERN-1: beat_phase <= 0 and adv_pending <= 1.
  - Else: beat_phase += 1.
- HOLD:
  - tick is ignored.
  - beat_phase and hue_acc are frozen.
  - Entering HOLD does not clear adv_pending.
- step: sets adv_pending=1 in either state. beat_phase is unchanged.
- adv_pending saturates. Any number of advance requests between two frame_starts yields exactly one advance.
- On frame_start:
  - hue <= hue_acc.
  - If adv_pending: pattern_sel <= (pattern_sel == NUM_PATTERNS-1) ? 0 : pattern_sel+1, adv_pending <= 0, and pattern_change = 1 on the next cycle.
  - If not adv_pending: pattern_sel is unchanged and no pattern_change pulse.
- Simultaneous tick or step with frame_start in the same cycle:
  - frame_start uses the adv_pending and hue_acc values registered before this edge.
  - The new tick or step request is retained for the next frame_start. adv_pending ends as 1, not cleared.
- Latency:
  - A request becomes visible on pattern_sel at the first frame_start strictly after the request cycle.
  - pattern_sel updates 1 clk after that frame_start edge.
  - pattern_change follows pattern_sel by 1 clk and is high for exactly 1 clk.
- No frame_start ever: pattern_sel and hue never change. hue_acc keeps wrapping mod 256.
- BEATS_PER_PATTERN=1: every RUN tick requests an advance.
- All outputs are registered. No combinational path from inputs to outputs.

Test Plan:
1. Reset and auto-advance:
   - Stimulus: rst_n low 3 cycles, then 4 ticks spaced 50 cycles, then frame_start.
   - Required: pattern_sel 0->1; hue=64; beat_phase 1,2,3,0; one pattern_change pulse.
2. Wrap:
   - Stimulus: 24 ticks, each beat group followed by a frame_start.
   - Required: pattern_sel goes 1,2,3,4,5,0. hue wraps 240->0 at tick 16.
3. Collapse:
   - Stimulus: step, step, 4 ticks, then one frame_start.
   - Required: pattern_sel advances by exactly 1.
   - A second frame_start with no new requests leaves pattern_sel unchanged.
4. HOLD:
   - Stimulus: hold=1, 8 ticks, frame_start.
   - Required: beat_phase, hue and pattern_sel unchanged.
   - Then step + frame_start -> pattern_sel +1 while hold=1.
5. Simultaneous events:
   - Stimulus: tick completing a beat group coincident with frame_start.
   - Required: no advance at that frame_start; advance at the next frame_start. hue at the first frame_start excludes that tick's step.
6. Reset mid-operation:
   - Stimulus: adv_pending=1 and hue_acc=48, then rst_n low 1 cycle, then frame_start.
   - Required: pattern_sel=0, hue=0, no pattern_change pulse.
